pif_i2c_master: RTL and testbench
=================================

Name: pif_i2c_master

Overview:
- Wishbone master sequencer that drives the EFB I2C2 port in I2C master mode.
- Issues complete I2C write or read transactions to a remote pif slave: START, 7-bit address, N data bytes, STOP.
- Sits beside the EFB on the shared wishbone bus and is the initiator counterpart of the pif I2C slave path.
- Byte-level framing (A_ADDR/D_ADDR type bits) belongs to the client; this block moves raw bytes.

Parameters:
- WB_BASE, 8'h4A, EFB address of I2C2_CR; register offsets +0 CR, +1 CMDR, +2 BR0, +3 BR1, +4 TXDR, +5 SR, +7 RXDR.
- BR_DIV, 10'd30, prescale written to BR1[1:0]/BR0[7:0] at init.
- TIMEOUT, 16'd50000, xclk cycles allowed per SR poll loop before abort.

Ports:
- xclk  in  1  clock
- sys_rst  in  1  reset, asynchronous, active-low
- wb_cyc_o  out  1  wishbone cycle
- wb_stb_o  out  1  wishbone strobe
- wb_we_o  out  1  wishbone write enable
- wb_adr_o  out  8  wishbone address
- wb_dat_o  out  8  wishbone write data
- wb_dat_i  in  8  wishbone read data
- wb_ack_i  in  1  wishbone acknowledge
- cmd_valid  in  1  transaction request
- cmd_ready  out  1  high in IDLE only; command accepted when valid & ready
- cmd_rnw  in  1  1 = read, 0 = write
- cmd_dev  in  7  slave address
- cmd_len  in  4  byte count; 0 = address-only probe
- tx_data  in  8  next write byte; must be stable until tx_take
- tx_take  out  1  one-cycle pulse: tx_data latched into TXDR write
- rx_data  out  8  received byte
- rx_valid  out  1  one-cycle pulse with rx_data
- done  out  1  one-cycle pulse at end of every accepted command
- nak  out  1  status of last command: address or data NAK; held until next accept
- tmo  out  1  status of last command: poll timeout; held until next accept
- busy  out  1  not in IDLE

Behaviour:
- Reset (sys_rst low, async): all outputs 0; state INIT_BR0. On release, init runs before cmd_ready rises.
- Init sequence: write BR0 = BR_DIV[7:0], write BR1 = BR_DIV[9:8], write CR = 8'h80, then IDLE.
- Wishbone write sub-state WBWR: drive cyc, stb, we, adr, dat until ack. On the ack cycle drop all three and return via a return-state register. The next cycle may start a new access (minimum 1 idle cycle).
- Wishbone read sub-state WBRD: same without we. Latch wb_dat_i on ack.
- Accept: latch rnw, dev, len; clear nak/tmo; cnt = len.
- ADDR: TXDR <= {dev, rnw}, then CMDR <= 8'h94 (STA|WR|CKSDIS). Enter POLL.
- POLL: read SR repeatedly until TRRDY (bit 2) = 1; the timeout counter clears on POLL entry.
  - RARC (bit 5) = 1 after any write phase: set nak, go STOP.
  - Timeout: set tmo, go STOP.
  - Arbitration-lost (bit 3): treated as nak.
- Write phase: if cnt = 0, STOP. Else pulse tx_take, TXDR <= tx_data, CMDR <= 8'h14, cnt--, POLL.
- Read phase: if cnt = 0, STOP.
  - cnt > 1: CMDR <= 8'h24 (RD|CKSDIS).
  - cnt = 1: CMDR <= 8'h6C (RD|STO|ACK|CKSDIS).
  - Then POLL for TRRDY, read RXDR, pulse rx_valid with data, cnt--.
  - After the last byte, go DONE directly; STOP has already been issued.
- STOP: CMDR <= 8'h44 (STO|CKSDIS); poll SR until BUSY (bit 6) = 0, subject to the same timeout; then DONE.
- DONE: pulse done; next cycle IDLE.
- Simultaneous events:
  - cmd_valid while busy is ignored; cmd_ready = 0.
  - A NAK on the address phase skips all data; no tx_take or rx_valid is emitted.
- tx_take pulses always equal the number of bytes actually sent; rx_valid pulses equal the bytes received.
- cnt is 4-bit and decrements only when > 0; no wrap.
- Reset mid-operation: wishbone signals drop asynchronously, the partial transaction is abandoned without done, and init re-runs.

Test Plan:
- Release reset with ack returned 1 cycle after stb → wishbone writes 0x4C=0x1E, 0x4D=0x00, 0x4A=0x80 in order; cmd_ready rises after the third ack.
- Write dev=0x41, len=2, tx bytes 0x81,0x55, SR returns 0x44 (BUSY|TRRDY) → TXDR 0x82, CMDR 0x94, 0x81, CMDR 0x14, 0x55, CMDR 0x14, CMDR 0x44; 2 tx_take, one done, nak=0.
- Write dev=0x41 with SR=0x64 (RARC) after the address → no tx_take, CMDR 0x44 issued, done with nak=1.
- Read dev=0x41, len=2, RXDR returns 0xA5 then 0x3C → CMDR 0x24 then 0x6C; rx_valid twice with 0xA5, 0x3C; no separate 0x44 write; done.
- Write len=1 with SR stuck at 0x40 and TIMEOUT=100 → tmo=1 after ~100 cycles, STOP issued, done pulse.
- Assert sys_rst during the data phase of a write → cyc/stb/we go 0 immediately; after release the init writes repeat and no done pulse appears for the aborted command.

Source files
------------

// File: rtl/pif_i2c_master.sv
// Wishbone initiator that sequences the EFB I2C2 port as an I2C master: START, 7-bit address,
// N raw data bytes, STOP. Reports NAK/arbitration loss and SR poll timeouts per command.
module pif_i2c_master #(
  parameter logic [7:0]  WB_BASE = 8'h4A,
  parameter logic [9:0]  BR_DIV  = 10'd30,
  parameter logic [15:0] TIMEOUT = 16'd50000
) (
  input  logic       xclk,
  input  logic       sys_rst,
  output logic       wb_cyc_o,
  output logic       wb_stb_o,
  output logic       wb_we_o,
  output logic [7:0] wb_adr_o,
  output logic [7:0] wb_dat_o,
  input  logic [7:0] wb_dat_i,
  input  logic       wb_ack_i,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rnw,
  input  logic [6:0] cmd_dev,
  input  logic [3:0] cmd_len,
  input  logic [7:0] tx_data,
  output logic       tx_take,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       done,
  output logic       nak,
  output logic       tmo,
  output logic       busy
);

  localparam logic [7:0] AdrCr   = WB_BASE;
  localparam logic [7:0] AdrCmdr = WB_BASE + 8'd1;
  localparam logic [7:0] AdrBr0  = WB_BASE + 8'd2;
  localparam logic [7:0] AdrBr1  = WB_BASE + 8'd3;
  localparam logic [7:0] AdrTxdr = WB_BASE + 8'd4;
  localparam logic [7:0] AdrSr   = WB_BASE + 8'd5;
  localparam logic [7:0] AdrRxdr = WB_BASE + 8'd7;

  localparam logic [7:0] CmdStartWr = 8'h94;
  localparam logic [7:0] CmdWr      = 8'h14;
  localparam logic [7:0] CmdRd      = 8'h24;
  localparam logic [7:0] CmdRdLast  = 8'h6C;
  localparam logic [7:0] CmdStop    = 8'h44;

  localparam int unsigned SrTrrdy = 2;
  localparam int unsigned SrArbl  = 3;
  localparam int unsigned SrRarc  = 5;
  localparam int unsigned SrBusy  = 6;

  typedef enum logic [4:0] {
    StInitBr0, StInitBr1, StInitCr, StIdle, StAddrTx, StAddrCmd, StPoll, StPollChk,
    StWrData, StWrCmd, StRdCmd, StRdData, StRdDone, StStop, StDone, StWbWr, StWbRd
  } state_e;

  // What a successful SR poll is waiting for.
  typedef enum logic [1:0] {PmWrite, PmRead, PmStop} pmode_e;

  state_e      state_q;
  state_e      ret_q;
  pmode_e      pmode_q;
  logic        rnw_q;
  logic [6:0]  dev_q;
  logic [3:0]  cnt_q;
  logic [7:0]  rdat_q;
  logic [15:0] tmo_cnt_q;
  logic        polling;
  logic        timed_out;

  // The SR read issued from a poll loop counts towards that loop's budget.
  assign polling   = (state_q == StPoll) || (state_q == StPollChk) ||
                     ((state_q == StWbRd) && (ret_q == StPollChk));
  assign timed_out = (tmo_cnt_q >= TIMEOUT);

  always_ff @(posedge xclk or negedge sys_rst) begin
    if (!sys_rst) begin
      state_q   <= StInitBr0;
      ret_q     <= StInitBr0;
      pmode_q   <= PmWrite;
      rnw_q     <= 1'b0;
      dev_q     <= 7'd0;
      cnt_q     <= 4'd0;
      rdat_q    <= 8'd0;
      tmo_cnt_q <= 16'd0;
      wb_cyc_o  <= 1'b0;
      wb_stb_o  <= 1'b0;
      wb_we_o   <= 1'b0;
      wb_adr_o  <= 8'd0;
      wb_dat_o  <= 8'd0;
      cmd_ready <= 1'b0;
      tx_take   <= 1'b0;
      rx_data   <= 8'd0;
      rx_valid  <= 1'b0;
      done      <= 1'b0;
      nak       <= 1'b0;
      tmo       <= 1'b0;
      busy      <= 1'b0;
    end else begin
      tx_take  <= 1'b0;
      rx_valid <= 1'b0;
      done     <= 1'b0;
      if (polling && !timed_out) begin
        tmo_cnt_q <= tmo_cnt_q + 16'd1;
      end

      unique case (state_q)
        StInitBr0: begin
          busy     <= 1'b1;
          wb_cyc_o <= 1'b1;
          wb_stb_o <= 1'b1;
          wb_we_o  <= 1'b1;
          wb_adr_o <= AdrBr0;
          wb_dat_o <= BR_DIV[7:0];
          ret_q    <= StInitBr1;
          state_q  <= StWbWr;
        end
        StInitBr1: begin
          wb_cyc_o <= 1'b1;
          wb_stb_o <= 1'b1;
          wb_we_o  <= 1'b1;
          wb_adr_o <= AdrBr1;
          wb_dat_o <= {6'd0, BR_DIV[9:8]};
          ret_q    <= StInitCr;
          state_q  <= StWbWr;
        end
        StInitCr: begin
          wb_cyc_o <= 1'b1;
          wb_stb_o <= 1'b1;
          wb_we_o  <= 1'b1;
          wb_adr_o <= AdrCr;
          wb_dat_o <= 8'h80;
          ret_q    <= StIdle;
          state_q  <= StWbWr;
        end
        StIdle: begin
          if (cmd_valid) begin
            rnw_q     <= cmd_rnw;
            dev_q     <= cmd_dev;
            cnt_q     <= cmd_len;
            nak       <= 1'b0;
            tmo       <= 1'b0;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            state_q   <= StAddrTx;
          end
        end
        StAddrTx: begin
          wb_cyc_o <= 1'b1;
          wb_stb_o <= 1'b1;
          wb_we_o  <= 1'b1;
          wb_adr_o <= AdrTxdr;
          wb_dat_o <= {dev_q, rnw_q};
          ret_q    <= StAddrCmd;
          state_q  <= StWbWr;
        end
        StAddrCmd: begin
          wb_cyc_o  <= 1'b1;
          wb_stb_o  <= 1'b1;
          wb_we_o   <= 1'b1;
          wb_adr_o  <= AdrCmdr;
          wb_dat_o  <= CmdStartWr;
          pmode_q   <= PmWrite;
          tmo_cnt_q <= 16'd0;
          ret_q     <= StPoll;
          state_q   <= StWbWr;
        end
        StPoll: begin
          wb_cyc_o <= 1'b1;
          wb_stb_o <= 1'b1;
          wb_we_o  <= 1'b0;
          wb_adr_o <= AdrSr;
          ret_q    <= StPollChk;
          state_q  <= StWbRd;
        end
        StPollChk: begin
          unique case (pmode_q)
            PmStop: begin
              if (!rdat_q[SrBusy]) begin
                state_q <= StDone;
              end else if (timed_out) begin
                tmo     <= 1'b1;
                state_q <= StDone;
              end else begin
                state_q <= StPoll;
              end
            end
            PmWrite: begin
              if (rdat_q[SrArbl] || (rdat_q[SrTrrdy] && rdat_q[SrRarc])) begin
                nak     <= 1'b1;
                state_q <= StStop;
              end else if (rdat_q[SrTrrdy]) begin
                // The address phase is a write phase for reads too.
                state_q <= rnw_q ? StRdCmd : StWrData;
              end else if (timed_out) begin
                tmo     <= 1'b1;
                state_q <= StStop;
              end else begin
                state_q <= StPoll;
              end
            end
            default: begin
              if (rdat_q[SrArbl]) begin
                nak     <= 1'b1;
                state_q <= StStop;
              end else if (rdat_q[SrTrrdy]) begin
                state_q <= StRdData;
              end else if (timed_out) begin
                tmo     <= 1'b1;
                state_q <= StStop;
              end else begin
                state_q <= StPoll;
              end
            end
          endcase
        end
        StWrData: begin
          if (cnt_q == 4'd0) begin
            state_q <= StStop;
          end else begin
            tx_take  <= 1'b1;
            wb_cyc_o <= 1'b1;
            wb_stb_o <= 1'b1;
            wb_we_o  <= 1'b1;
            wb_adr_o <= AdrTxdr;
            wb_dat_o <= tx_data;
            cnt_q    <= cnt_q - 4'd1;
            ret_q    <= StWrCmd;
            state_q  <= StWbWr;
          end
        end
        StWrCmd: begin
          wb_cyc_o  <= 1'b1;
          wb_stb_o  <= 1'b1;
          wb_we_o   <= 1'b1;
          wb_adr_o  <= AdrCmdr;
          wb_dat_o  <= CmdWr;
          pmode_q   <= PmWrite;
          tmo_cnt_q <= 16'd0;
          ret_q     <= StPoll;
          state_q   <= StWbWr;
        end
        StRdCmd: begin
          if (cnt_q == 4'd0) begin
            state_q <= StStop;
          end else begin
            wb_cyc_o  <= 1'b1;
            wb_stb_o  <= 1'b1;
            wb_we_o   <= 1'b1;
            wb_adr_o  <= AdrCmdr;
            // The last byte is NAKed and followed by STOP in the same command.
            wb_dat_o  <= (cnt_q == 4'd1) ? CmdRdLast : CmdRd;
            pmode_q   <= PmRead;
            tmo_cnt_q <= 16'd0;
            ret_q     <= StPoll;
            state_q   <= StWbWr;
          end
        end
        StRdData: begin
          wb_cyc_o <= 1'b1;
          wb_stb_o <= 1'b1;
          wb_we_o  <= 1'b0;
          wb_adr_o <= AdrRxdr;
          ret_q    <= StRdDone;
          state_q  <= StWbRd;
        end
        StRdDone: begin
          rx_valid <= 1'b1;
          rx_data  <= rdat_q;
          cnt_q    <= cnt_q - 4'd1;
          state_q  <= (cnt_q == 4'd1) ? StDone : StRdCmd;
        end
        StStop: begin
          wb_cyc_o  <= 1'b1;
          wb_stb_o  <= 1'b1;
          wb_we_o   <= 1'b1;
          wb_adr_o  <= AdrCmdr;
          wb_dat_o  <= CmdStop;
          pmode_q   <= PmStop;
          tmo_cnt_q <= 16'd0;
          ret_q     <= StPoll;
          state_q   <= StWbWr;
        end
        StDone: begin
          done      <= 1'b1;
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
          state_q   <= StIdle;
        end
        StWbWr: begin
          if (wb_ack_i) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_we_o  <= 1'b0;
            state_q  <= ret_q;
            if (ret_q == StIdle) begin
              cmd_ready <= 1'b1;
              busy      <= 1'b0;
            end
          end
        end
        StWbRd: begin
          if (wb_ack_i) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            rdat_q   <= wb_dat_i;
            state_q  <= ret_q;
          end
        end
        default: state_q <= StInitBr0;
      endcase
    end
  end

endmodule

// File: tb/tb_pif_i2c_master.sv
// Directed bench for pif_i2c_master with a small EFB register model on the wishbone side.
module tb_pif_i2c_master;

  logic       xclk = 1'b0;
  logic       sys_rst = 1'b0;
  logic       wb_cyc_o, wb_stb_o, wb_we_o;
  logic [7:0] wb_adr_o, wb_dat_o;
  logic [7:0] wb_dat_i = 8'd0;
  logic       wb_ack_i = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_rnw = 1'b0;
  logic [6:0] cmd_dev = 7'd0;
  logic [3:0] cmd_len = 4'd0;
  logic [7:0] tx_data;
  logic       tx_take;
  logic [7:0] rx_data;
  logic       rx_valid, done, nak, tmo, busy;

  int total = 0;
  int bad = 0;

  logic       clr = 1'b0;
  logic [7:0] sr_val = 8'h44;
  logic       stop_seen = 1'b0;
  logic [7:0] tx_bytes [0:7];
  logic [7:0] rx_bytes [0:7];
  logic [7:0] wr_adr [0:31];
  logic [7:0] wr_dat [0:31];
  logic [7:0] rx_log [0:7];
  int n_wr = 0, n_take = 0, n_rx = 0, n_done = 0, tx_idx = 0, rx_idx = 0;

  always #5 xclk = ~xclk;

  pif_i2c_master #(.TIMEOUT(16'd100)) dut (
    .xclk(xclk), .sys_rst(sys_rst),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rnw(cmd_rnw), .cmd_dev(cmd_dev),
    .cmd_len(cmd_len), .tx_data(tx_data), .tx_take(tx_take), .rx_data(rx_data),
    .rx_valid(rx_valid), .done(done), .nak(nak), .tmo(tmo), .busy(busy)
  );

  assign tx_data = tx_bytes[tx_idx[2:0]];

  // EFB model: ack one cycle after strobe; STO in CMDR clears SR.BUSY, STA sets it again.
  always @(posedge xclk) begin
    wb_ack_i <= wb_cyc_o && wb_stb_o && !wb_ack_i;
    if (wb_cyc_o && wb_stb_o && !wb_ack_i) begin
      if (wb_we_o && wb_adr_o == 8'h4B) begin
        if (wb_dat_o[7]) stop_seen <= 1'b0;
        else if (wb_dat_o[6]) stop_seen <= 1'b1;
      end
      if (!wb_we_o) begin
        if (wb_adr_o == 8'h51) wb_dat_i <= rx_bytes[rx_idx[2:0]];
        else wb_dat_i <= stop_seen ? (sr_val & 8'hBF) : sr_val;
      end
    end
    if (clr) begin
      n_wr <= 0; n_take <= 0; n_rx <= 0; n_done <= 0; tx_idx <= 0; rx_idx <= 0;
    end else begin
      if (wb_cyc_o && wb_stb_o && !wb_ack_i && wb_we_o && n_wr < 32) begin
        wr_adr[n_wr] <= wb_adr_o;
        wr_dat[n_wr] <= wb_dat_o;
        n_wr <= n_wr + 1;
      end
      if (wb_cyc_o && wb_stb_o && !wb_ack_i && !wb_we_o && wb_adr_o == 8'h51)
        rx_idx <= rx_idx + 1;
      if (tx_take) begin n_take <= n_take + 1; tx_idx <= tx_idx + 1; end
      if (rx_valid && n_rx < 8) begin rx_log[n_rx] <= rx_data; n_rx <= n_rx + 1; end
      if (done) n_done <= n_done + 1;
    end
  end

  task automatic do_clear();
    @(negedge xclk); clr = 1'b1;
    @(negedge xclk); clr = 1'b0;
  endtask

  task automatic start_cmd(input logic rnw, input logic [6:0] dev, input logic [3:0] len,
                           output bit ok);
    int n = 0;
    while (!cmd_ready && n < 500) begin @(negedge xclk); n++; end
    ok = cmd_ready;
    cmd_rnw = rnw; cmd_dev = dev; cmd_len = len; cmd_valid = 1'b1;
    @(negedge xclk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok, output int cycles);
    cycles = 0;
    while (n_done == 0 && cycles < budget) begin @(negedge xclk); cycles++; end
    ok = (n_done != 0);
    repeat (3) @(negedge xclk);
  endtask

  task automatic test_reset();
    logic [15:0] exp_w [3] = '{16'h4C1E, 16'h4D00, 16'h4A80};
    int n = 0;
    #1;
    total++;
    if ({wb_cyc_o, wb_stb_o, wb_we_o, cmd_ready, tx_take, rx_valid, done, nak, tmo, busy}
        !== 10'd0) begin
      bad++; $display("FAIL reset_outputs: got nonzero outputs busy=%b cyc=%b", busy, wb_cyc_o);
    end
    do_clear();
    sys_rst = 1'b1;
    while (!cmd_ready && n < 200) begin @(negedge xclk); n++; end
    total++;
    if (n_wr !== 3) begin bad++; $display("FAIL init_ready: writes=%0d want 3", n_wr); end
    for (int i = 0; i < 3; i++) begin
      total++;
      if ({wr_adr[i], wr_dat[i]} !== exp_w[i]) begin
        bad++; $display("FAIL init_wr[%0d]: got %h want %h", i, {wr_adr[i], wr_dat[i]}, exp_w[i]);
      end
    end
  endtask

  task automatic test_write();
    logic [15:0] exp_w [7] = '{16'h4E82, 16'h4B94, 16'h4E81, 16'h4B14, 16'h4E55, 16'h4B14,
                               16'h4B44};
    bit ok; int cyc;
    do_clear();
    sr_val = 8'h44; tx_bytes[0] = 8'h81; tx_bytes[1] = 8'h55;
    start_cmd(1'b0, 7'h41, 4'd2, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL write_accept: cmd_ready=0 want 1"); end
    repeat (2) @(negedge xclk);
    total++;
    if ({cmd_ready, busy} !== 2'b01) begin
      bad++; $display("FAIL write_busy: ready/busy=%b%b want 01", cmd_ready, busy);
    end
    cmd_rnw = 1'b1; cmd_len = 4'd0; cmd_valid = 1'b1;
    @(negedge xclk);
    cmd_valid = 1'b0;
    wait_done(500, ok, cyc);
    total++;
    if (!ok) begin bad++; $display("FAIL write_done: no done within 500 cycles"); end
    total++;
    if (n_wr !== 7) begin bad++; $display("FAIL write_count: got %0d want 7", n_wr); end
    for (int i = 0; i < 7; i++) begin
      total++;
      if ({wr_adr[i], wr_dat[i]} !== exp_w[i]) begin
        bad++; $display("FAIL write_wr[%0d]: got %h want %h", i, {wr_adr[i], wr_dat[i]}, exp_w[i]);
      end
    end
    total++;
    if ({n_take, n_done} !== {32'd2, 32'd1} || nak !== 1'b0 || tmo !== 1'b0) begin
      bad++; $display("FAIL write_status: take=%0d done=%0d nak=%b tmo=%b want 2 1 0 0",
                      n_take, n_done, nak, tmo);
    end
  endtask

  task automatic test_probe();
    logic [15:0] exp_w [3] = '{16'h4E20, 16'h4B94, 16'h4B44};
    bit ok; int cyc;
    do_clear();
    sr_val = 8'h44;
    start_cmd(1'b0, 7'h10, 4'd0, ok);
    wait_done(500, ok, cyc);
    total++;
    if (!ok || n_wr !== 3 || n_take !== 0) begin
      bad++; $display("FAIL probe_status: done=%b writes=%0d take=%0d want 1 3 0", ok, n_wr, n_take);
    end
    for (int i = 0; i < 3; i++) begin
      total++;
      if ({wr_adr[i], wr_dat[i]} !== exp_w[i]) begin
        bad++; $display("FAIL probe_wr[%0d]: got %h want %h", i, {wr_adr[i], wr_dat[i]}, exp_w[i]);
      end
    end
  endtask

  task automatic test_nak();
    logic [15:0] exp_w [3] = '{16'h4E82, 16'h4B94, 16'h4B44};
    bit ok; int cyc;
    do_clear();
    sr_val = 8'h64; tx_bytes[0] = 8'h11; tx_bytes[1] = 8'h22;
    start_cmd(1'b0, 7'h41, 4'd2, ok);
    wait_done(500, ok, cyc);
    total++;
    if (!ok || nak !== 1'b1 || tmo !== 1'b0 || n_take !== 0 || n_done !== 1) begin
      bad++; $display("FAIL nak_status: done=%b nak=%b tmo=%b take=%0d want 1 1 0 0",
                      ok, nak, tmo, n_take);
    end
    total++;
    if (n_wr !== 3) begin bad++; $display("FAIL nak_count: got %0d want 3", n_wr); end
    for (int i = 0; i < 3; i++) begin
      total++;
      if ({wr_adr[i], wr_dat[i]} !== exp_w[i]) begin
        bad++; $display("FAIL nak_wr[%0d]: got %h want %h", i, {wr_adr[i], wr_dat[i]}, exp_w[i]);
      end
    end
  endtask

  task automatic test_read();
    logic [15:0] exp_w [4] = '{16'h4E83, 16'h4B94, 16'h4B24, 16'h4B6C};
    bit ok; int cyc;
    do_clear();
    sr_val = 8'h44; rx_bytes[0] = 8'hA5; rx_bytes[1] = 8'h3C;
    start_cmd(1'b1, 7'h41, 4'd2, ok);
    wait_done(500, ok, cyc);
    total++;
    if (!ok || n_done !== 1 || nak !== 1'b0) begin
      bad++; $display("FAIL read_done: done=%b count=%0d nak=%b want 1 1 0", ok, n_done, nak);
    end
    total++;
    if (n_wr !== 4) begin bad++; $display("FAIL read_count: got %0d want 4", n_wr); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if ({wr_adr[i], wr_dat[i]} !== exp_w[i]) begin
        bad++; $display("FAIL read_wr[%0d]: got %h want %h", i, {wr_adr[i], wr_dat[i]}, exp_w[i]);
      end
    end
    total++;
    if (n_rx !== 2 || rx_log[0] !== 8'hA5 || rx_log[1] !== 8'h3C) begin
      bad++; $display("FAIL read_data: n=%0d got %h %h want a5 3c", n_rx, rx_log[0], rx_log[1]);
    end
  endtask

  task automatic test_timeout();
    logic [15:0] exp_w [3] = '{16'h4E82, 16'h4B94, 16'h4B44};
    bit ok; int cyc;
    do_clear();
    sr_val = 8'h40; tx_bytes[0] = 8'h77;
    start_cmd(1'b0, 7'h41, 4'd1, ok);
    wait_done(1000, ok, cyc);
    total++;
    if (!ok || tmo !== 1'b1 || nak !== 1'b0 || n_take !== 0) begin
      bad++; $display("FAIL tmo_status: done=%b tmo=%b nak=%b take=%0d want 1 1 0 0",
                      ok, tmo, nak, n_take);
    end
    total++;
    if (cyc < 100 || cyc > 300) begin
      bad++; $display("FAIL tmo_latency: got %0d cycles want 100..300", cyc);
    end
    for (int i = 0; i < 3; i++) begin
      total++;
      if ({wr_adr[i], wr_dat[i]} !== exp_w[i]) begin
        bad++; $display("FAIL tmo_wr[%0d]: got %h want %h", i, {wr_adr[i], wr_dat[i]}, exp_w[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] exp_w [3] = '{16'h4C1E, 16'h4D00, 16'h4A80};
    bit ok; int n = 0;
    do_clear();
    sr_val = 8'h44; tx_bytes[0] = 8'h01; tx_bytes[1] = 8'h02; tx_bytes[2] = 8'h03;
    start_cmd(1'b0, 7'h41, 4'd3, ok);
    while (!(n_take >= 1 && wb_cyc_o) && n < 500) begin @(negedge xclk); n++; end
    total++;
    if (!(n_take >= 1 && wb_cyc_o)) begin
      bad++; $display("FAIL midrst_reach: take=%0d cyc=%b want >=1 1", n_take, wb_cyc_o);
    end
    sys_rst = 1'b0;
    #1;
    total++;
    if ({wb_cyc_o, wb_stb_o, wb_we_o, busy} !== 4'b0000) begin
      bad++; $display("FAIL midrst_drop: cyc/stb/we/busy=%b%b%b%b want 0000",
                      wb_cyc_o, wb_stb_o, wb_we_o, busy);
    end
    do_clear();
    sys_rst = 1'b1;
    n = 0;
    while (!cmd_ready && n < 200) begin @(negedge xclk); n++; end
    repeat (5) @(negedge xclk);
    total++;
    if (n_wr !== 3 || n_done !== 0 || cmd_ready !== 1'b1) begin
      bad++; $display("FAIL midrst_reinit: writes=%0d done=%0d ready=%b want 3 0 1",
                      n_wr, n_done, cmd_ready);
    end
    for (int i = 0; i < 3; i++) begin
      total++;
      if ({wr_adr[i], wr_dat[i]} !== exp_w[i]) begin
        bad++; $display("FAIL midrst_wr[%0d]: got %h want %h", i, {wr_adr[i], wr_dat[i]}, exp_w[i]);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin tx_bytes[i] = 8'h00; rx_bytes[i] = 8'h00; end
    repeat (3) @(negedge xclk);
    test_reset();
    test_write();
    test_probe();
    test_nak();
    test_read();
    test_timeout();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
